// File: rtl/neuron_buffer_loader.sv
// Streams neuron words into a banked neuron buffer through its serial port.
// A load starts at row baseAddr, fills banks 0..D-1 of each row in turn, and
// finishes with a one-cycle FLUSH that carries the last write plus done.
module neuron_buffer_loader #(
  parameter int depth = 2,
  parameter int A     = 7,
  parameter int D     = 1 << depth,
  parameter int W     = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [A-1:0]         baseAddr,
  input  logic [A+depth-1:0]   numWords,
  input  logic [W-1:0]         inData,
  input  logic                 inValid,
  output logic                 inReady,
  output logic [A-1:0]         address,
  output logic [W+depth+1:0]   ioInputs,
  output logic                 busy,
  output logic                 done
);

  localparam int NW = A + depth;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [A-1:0]      row_q, row_d;
  logic [NW-1:0]     rem_q, rem_d;
  logic [depth-1:0]  bank_q, bank_d;
  logic              hs;

  logic              wr_q;
  logic [W-1:0]      wdata_q;
  logic [depth-1:0]  wbank_q;
  logic [A-1:0]      waddr_q;
  logic              zdone_q;

  // State and load counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      row_q   <= '0;
      rem_q   <= '0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      rem_q   <= rem_d;
      bank_q  <= bank_d;
    end
  end

  // Next-state logic, handshake and counter advance.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    rem_d   = rem_q;
    bank_d  = bank_q;
    inReady = (state_q == LOAD);
    hs      = inValid & inReady;
    case (state_q)
      IDLE: begin
        if (start && (numWords != '0)) begin
          row_d   = baseAddr;
          rem_d   = numWords;
          bank_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (hs) begin
          bank_d = bank_q + 1'b1;
          if (bank_q == depth'(D - 1)) begin
            row_d = row_q + 1'b1;
          end
          rem_d = rem_q - 1'b1;
          if (rem_q == NW'(1)) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write register: each handshake is presented to the buffer one cycle later;
  // data/bank/address hold between writes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_q    <= 1'b0;
      wdata_q <= '0;
      wbank_q <= '0;
      waddr_q <= '0;
      zdone_q <= 1'b0;
    end else begin
      wr_q    <= hs;
      zdone_q <= (state_q == IDLE) && start && (numWords == '0);
      if (hs) begin
        wdata_q <= inData;
        wbank_q <= bank_q;
        waddr_q <= row_q;
      end
    end
  end

  // Output gating: the serial port is fully quiet whenever no load is active.
  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == FLUSH) | zdone_q;
    ioInputs = busy ? {1'b1, wr_q, wbank_q, wdata_q} : '0;
    address  = busy ? waddr_q : '0;
  end

endmodule

// File: tb/tb_neuron_buffer_loader.sv
// Bench for neuron_buffer_loader: a word-index reference model checked every
// cycle, directed load scenarios with literal expectations, then random traffic.
module tb_neuron_buffer_loader;

  localparam int DEPTH = 2;
  localparam int A     = 7;
  localparam int W     = 16;
  localparam int D     = 1 << DEPTH;
  localparam int NW    = A + DEPTH;
  localparam int IW    = W + DEPTH + 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [A-1:0]  baseAddr = '0;
  logic [NW-1:0] numWords = '0;
  logic [W-1:0]  inData = '0;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [A-1:0]  address;
  logic [IW-1:0] ioInputs;
  logic          busy;
  logic          done;

  always #5 CLK = ~CLK;

  neuron_buffer_loader #(.depth(DEPTH), .A(A), .W(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .baseAddr(baseAddr), .numWords(numWords),
    .inData(inData), .inValid(inValid), .inReady(inReady), .address(address),
    .ioInputs(ioInputs), .busy(busy), .done(done)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a load is described by base row, word count and the
  // index of the next word; word i lands at row base+i/D, bank i%D.
  bit               m_loading, m_flush, m_zdone, m_wr;
  int               m_idx, m_total, m_base;
  logic [W-1:0]     m_data;
  logic [DEPTH-1:0] m_bank;
  logic [A-1:0]     m_addr;

  task automatic m_reset();
    m_loading = 0; m_flush = 0; m_zdone = 0; m_wr = 0;
    m_idx = 0; m_total = 0; m_base = 0;
    m_data = '0; m_bank = '0; m_addr = '0;
  endtask

  initial m_reset();

  typedef struct { int c; int addr; int bank; int data; } wr_t;
  wr_t wlog[$];
  int  dlog[$];
  int  blast = -1;
  int  cyc = 0;

  // Per-cycle compare against the model, then advance the model with this
  // cycle's inputs.
  always @(negedge CLK) begin
    bit            eb, idle, hs;
    logic [IW-1:0] eio;
    if (RST) m_reset();
    eb  = m_loading || m_flush;
    eio = eb ? {1'b1, m_wr, m_bank, m_data} : '0;
    chk("busy", busy, eb);
    chk("inReady", inReady, m_loading);
    chk("done", done, m_flush || m_zdone);
    chk("ioInputs", ioInputs, eio);
    chk("address", address, eb ? m_addr : '0);
    if (ioInputs[IW-2])
      wlog.push_back('{cyc, int'(address), int'(ioInputs[W+DEPTH-1:W]), int'(ioInputs[W-1:0])});
    if (done) dlog.push_back(cyc);
    if (busy) blast = cyc;
    if (!RST) begin
      idle    = !m_loading && !m_flush;
      hs      = m_loading && inValid;
      m_zdone = idle && start && (numWords == '0);
      m_flush = 0;
      m_wr    = hs;
      if (hs) begin
        m_data = inData;
        m_bank = DEPTH'(m_idx % D);
        m_addr = A'((m_base + m_idx / D) % (1 << A));
        m_idx++;
        if (m_idx == m_total) begin
          m_loading = 0;
          m_flush   = 1;
        end
      end
      if (idle && start && (numWords != '0)) begin
        m_loading = 1;
        m_idx     = 0;
        m_total   = int'(numWords);
        m_base    = int'(baseAddr);
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    wlog.delete();
    dlog.delete();
    blast = -1;
  endtask

  task automatic do_start(input int b, input int n);
    start    = 1'b1;
    baseAddr = A'(b);
    numWords = NW'(n);
    tick();
    start    = 1'b0;
  endtask

  task automatic feed(input int n, input logic [W-1:0] d0, input int dens);
    int cnt = 0;
    int g   = 0;
    while (cnt < n && g < 400) begin
      inValid = ($urandom_range(0, 99) < dens);
      inData  = inValid ? d0 + W'(cnt) : W'($urandom);
      if (inValid && inReady) cnt++;
      tick();
      g++;
    end
    inValid = 1'b0;
    chk("feed_count", cnt, n);
  endtask

  initial begin
    int sc;
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int hsc[4] = '{0, 3, 4, 6};
    int cnt;

    // Reset held with random inputs: model expects all-zero outputs.
    for (int i = 0; i < 8; i++) begin
      start = 1'($urandom); baseAddr = A'($urandom); numWords = NW'($urandom);
      inValid = 1'($urandom); inData = W'($urandom);
      tick();
    end
    RST = 1'b0; start = 1'b0; inValid = 1'b0;
    tick(); tick();

    // Six words from row 5, continuous valid.
    clear_logs();
    sc = cyc;
    do_start(5, 6);
    feed(6, 16'h0100, 100);
    tick(); tick();
    chk("s1_nwrites", wlog.size(), 6);
    if (wlog.size() == 6) begin
      chk("s1_first_cycle", wlog[0].c, sc + 2);
      for (int k = 0; k < 6; k++) begin
        chk("s1_addr", wlog[k].addr, (k < 4) ? 5 : 6);
        chk("s1_bank", wlog[k].bank, k % 4);
        chk("s1_data", wlog[k].data, 32'h0100 + k);
        chk("s1_cycle", wlog[k].c, sc + 2 + k);
      end
      chk("s1_ndone", dlog.size(), 1);
      if (dlog.size() == 1) chk("s1_done_cycle", dlog[0], wlog[5].c);
      chk("s1_busy_last", blast, wlog[5].c);
    end

    // Zero-length load.
    clear_logs();
    sc = cyc;
    do_start(33, 0);
    tick(); tick(); tick();
    chk("s2_ndone", dlog.size(), 1);
    if (dlog.size() == 1) chk("s2_done_cycle", dlog[0], sc + 1);
    chk("s2_nwrites", wlog.size(), 0);
    chk("s2_busy_never", blast, -1);

    // Four words with valid pattern 1,0,0,1,1,0,1.
    clear_logs();
    sc = cyc;
    do_start(40, 4);
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      inValid = pat[i][0];
      inData  = 16'h0200 + W'(cnt);
      if (inValid && inReady) cnt++;
      tick();
    end
    inValid = 1'b0;
    tick(); tick();
    chk("s3_nwrites", wlog.size(), 4);
    if (wlog.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("s3_cycle", wlog[k].c, sc + 2 + hsc[k]);
        chk("s3_bank", wlog[k].bank, k);
        chk("s3_data", wlog[k].data, 32'h0200 + k);
        chk("s3_addr", wlog[k].addr, 40);
      end
    end

    // Row wrap at 127 with a stray start mid-load.
    clear_logs();
    do_start(127, 5);
    cnt = 0;
    for (int g = 0; g < 40 && cnt < 5; g++) begin
      inValid  = 1'b1;
      inData   = 16'h0300 + W'(cnt);
      start    = (g == 2);
      baseAddr = 7'd3;
      numWords = NW'(2);
      if (inReady) cnt++;
      tick();
    end
    start = 1'b0; inValid = 1'b0;
    tick(); tick(); tick();
    chk("s4_nwrites", wlog.size(), 5);
    if (wlog.size() == 5) begin
      for (int k = 0; k < 4; k++) chk("s4_addr", wlog[k].addr, 127);
      chk("s4_fifth_addr", wlog[4].addr, 0);
      chk("s4_fifth_bank", wlog[4].bank, 0);
      chk("s4_fifth_data", wlog[4].data, 32'h0304);
    end

    // Reset mid-load, then a fresh one-word load.
    clear_logs();
    do_start(20, 8);
    feed(2, 16'h0400, 100);
    RST = 1'b1;
    #1;
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_ready", inReady, 0);
    chk("s5_rst_io", ioInputs, 0);
    chk("s5_rst_addr", address, 0);
    chk("s5_rst_done", done, 0);
    tick();
    RST = 1'b0;
    clear_logs();
    do_start(10, 1);
    feed(1, 16'h04AA, 100);
    tick(); tick();
    chk("s5_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) begin
      chk("s5_addr", wlog[0].addr, 10);
      chk("s5_bank", wlog[0].bank, 0);
      chk("s5_data", wlog[0].data, 32'h04AA);
      chk("s5_ndone", dlog.size(), 1);
      if (dlog.size() == 1) chk("s5_done_cycle", dlog[0], wlog[0].c);
    end

    // Random traffic, including occasional resets and long loads.
    for (int i = 0; i < 3000; i++) begin
      int dens;
      dens     = ((i / 500) % 3 == 0) ? 100 : ((i / 500) % 3 == 1) ? 60 : 20;
      RST      = ($urandom_range(0, 299) == 0);
      start    = ($urandom_range(0, 9) == 0);
      baseAddr = A'($urandom);
      if ($urandom_range(0, 4) == 0)       numWords = '0;
      else if ($urandom_range(0, 19) == 0) numWords = NW'($urandom_range(100, 300));
      else                                 numWords = NW'($urandom_range(1, 10));
      inValid  = ($urandom_range(0, 99) < dens);
      inData   = W'($urandom);
      tick();
    end
    RST = 1'b0; start = 1'b0; inValid = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
